// File: rtl/spi_byte_slave_pkg.sv
// Shared types and constants for the SPI byte slave: FSM state encoding,
// byte width and the default idle byte shifted on MISO.
package spi_byte_slave_pkg;

  localparam int SPI_BYTE_W = 8;

  localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_BYTE_DEF = 8'h00;

  typedef enum logic {
    SPI_IDLE  = 1'b0,
    SPI_SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Flop-chain synchroniser for one asynchronous input; RESET_VAL sets the
// value every stage takes during reset (1 for the active-low chip select).
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chain <= {STAGES{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/spi_byte_slave.sv
// SPI mode-0 slave front end: oversamples SCLK/CS_N/MOSI in the clk domain,
// emits one-clk byte strobes and serialises response bytes on MISO.
// Optional macro SPI_MISO_OE_EN adds a registered miso_oe output.
module spi_byte_slave
  import spi_byte_slave_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = SPI_IDLE_BYTE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
`ifdef SPI_MISO_OE_EN
  output logic                  miso_oe,
`endif
  output logic [SPI_BYTE_W-1:0] dataw,
  output logic                  valid,
  input  logic [SPI_BYTE_W-1:0] datar,
  input  logic                  ready,
  output logic                  busy,
  output logic                  frame_err
);

  logic w_sclk_s;
  logic w_cs_s;
  logic w_mosi_s;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_fall;
  logic [SPI_BYTE_W-1:0] w_load_byte;

  spi_state_e            r_state;
  logic                  r_sclk_d;
  logic                  r_cs_d;
  logic [2:0]            r_bit_cnt;
  logic [SPI_BYTE_W-2:0] r_rx_sr;
  logic [SPI_BYTE_W-2:0] r_tx_sr;
  logic [SPI_BYTE_W-1:0] r_tx_buf;
  logic                  r_tx_pend;
  logic                  r_miso;
  logic [SPI_BYTE_W-1:0] r_dataw;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_frame_err;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(w_sclk_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs_n), .q(w_cs_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(w_mosi_s)
  );

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_cs_fall   = ~w_cs_s & r_cs_d;

  // MISO bit 7 goes straight to r_miso on a load; r_tx_sr keeps the remaining 7 bits.
  assign w_load_byte = r_tx_pend ? r_tx_buf : IDLE_BYTE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= SPI_IDLE;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
      r_bit_cnt   <= '0;
      r_rx_sr     <= '0;
      r_tx_sr     <= IDLE_BYTE[SPI_BYTE_W-2:0];
      r_tx_buf    <= IDLE_BYTE;
      r_tx_pend   <= 1'b0;
      r_miso      <= 1'b0;
      r_dataw     <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        SPI_IDLE: begin
          if (w_cs_fall) begin
            r_state   <= SPI_SHIFT;
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
            r_miso    <= w_load_byte[SPI_BYTE_W-1];
            r_tx_sr   <= w_load_byte[SPI_BYTE_W-2:0];
            r_tx_pend <= 1'b0;
          end
        end

        SPI_SHIFT: begin
          if (w_cs_s) begin
            r_state     <= SPI_IDLE;
            r_busy      <= 1'b0;
            r_frame_err <= (r_bit_cnt != 3'd0);
            r_bit_cnt   <= '0;
            r_miso      <= 1'b0;
          end else if (w_sclk_rise) begin
            r_rx_sr   <= {r_rx_sr[SPI_BYTE_W-3:0], w_mosi_s};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_dataw <= {r_rx_sr, w_mosi_s};
              r_valid <= 1'b1;
            end
          end else if (w_sclk_fall) begin
            if (r_bit_cnt != 3'd0) begin
              r_miso  <= r_tx_sr[SPI_BYTE_W-2];
              r_tx_sr <= {r_tx_sr[SPI_BYTE_W-3:0], 1'b0};
            end else begin
              r_miso    <= w_load_byte[SPI_BYTE_W-1];
              r_tx_sr   <= w_load_byte[SPI_BYTE_W-2:0];
              r_tx_pend <= 1'b0;
            end
          end
        end

        default: r_state <= SPI_IDLE;
      endcase

      // Placed last so a same-cycle response survives a boundary load that
      // consumed the older buffer contents.
      if (ready) begin
        r_tx_buf  <= datar;
        r_tx_pend <= 1'b1;
      end
    end
  end

  assign dataw     = r_dataw;
  assign valid     = r_valid;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;

`ifdef SPI_MISO_OE_EN
  assign miso_oe = r_busy;
  assign miso    = r_miso & r_busy;
`else
  assign miso    = r_miso;
`endif

endmodule
